// File: rtl/axil_cmd_pkg.sv
// Shared definitions for axil_cmd_master: FSM state encoding and AXI response codes.
package axil_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-command AXI4-Lite master: accepts one read/write command, runs the AXI transaction, strobes the response.
// Optional macro AXIL_CMD_ERR_EN adds o_rsp_err (bresp[1]/rresp[1] captured with the response strobe).
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CMD_AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_write,
  input  logic [31:0]       i_data,
  input  logic [CMD_AW-1:0] i_addr,
  output logic              o_cmd_busy,
  output logic              o_rsp_stb,
  output logic [31:0]       o_rsp_word,
`ifdef AXIL_CMD_ERR_EN
  output logic              o_rsp_err,
`endif
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_awaddr,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [31:0]       m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp
);

  state_t      r_state;
  logic        r_busy;
  logic        r_stb;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_word;
  logic [31:0] w_addr;
  logic        w_accept;
  logic        w_aw_done;
  logic        w_w_done;

  // Word index to byte address; the 32-bit add wraps silently.
  assign w_addr    = BASE_ADDR + 32'({i_addr, 2'b00});
  assign w_accept  = i_valid && !r_busy;
  assign w_aw_done = !r_awvalid || m_awready;
  assign w_w_done  = !r_wvalid  || m_wready;

`ifdef AXIL_CMD_ERR_EN
  logic r_err;
  logic w_unused_resp;
  assign w_unused_resp = ^{m_bresp[0], m_rresp[0]};
  assign o_rsp_err     = r_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{m_bresp, m_rresp};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_stb      <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_word <= '0;
`ifdef AXIL_CMD_ERR_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= w_addr;
            r_wdata <= i_data;
            r_busy  <= 1'b1;
            if (i_write) begin
              r_state   <= WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= RD_REQ;
              r_arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (m_awready) r_awvalid <= 1'b0;
          if (m_wready)  r_wvalid  <= 1'b0;
          // Either channel may already be done from an earlier cycle, or finish now.
          if (w_aw_done && w_w_done) begin
            r_state  <= WR_RESP;
            r_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            r_state    <= IDLE;
            r_bready   <= 1'b0;
            r_busy     <= 1'b0;
            r_stb      <= 1'b1;
            r_rsp_word <= '0;
`ifdef AXIL_CMD_ERR_EN
            r_err      <= m_bresp[1];
`endif
          end
        end
        RD_REQ: begin
          if (m_arready) begin
            r_state   <= RD_DATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            r_state    <= IDLE;
            r_rready   <= 1'b0;
            r_busy     <= 1'b0;
            r_stb      <= 1'b1;
            r_rsp_word <= m_rdata;
`ifdef AXIL_CMD_ERR_EN
            r_err      <= m_rresp[1];
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_busy = r_busy;
  assign o_rsp_stb  = r_stb;
  assign o_rsp_word = r_rsp_word;
  assign m_awvalid  = r_awvalid;
  assign m_awaddr   = r_addr;
  assign m_wvalid   = r_wvalid;
  assign m_wdata    = r_wdata;
  assign m_wstrb    = 4'hF;
  assign m_bready   = r_bready;
  assign m_arvalid  = r_arvalid;
  assign m_araddr   = r_addr;
  assign m_rready   = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master with a configurable-latency AXI4-Lite slave.
module tb_axil_cmd_master;
  import axil_cmd_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk, rst;
  logic        i_valid, i_write;
  logic [31:0] i_data;
  logic [3:0]  i_addr;
  logic        o_cmd_busy, o_rsp_stb;
  logic [31:0] o_rsp_word;
`ifdef AXIL_CMD_ERR_EN
  logic        o_rsp_err;
`endif
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  axil_cmd_master #(.BASE_ADDR(BASE), .CMD_AW(4)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_write(i_write), .i_data(i_data), .i_addr(i_addr),
    .o_cmd_busy(o_cmd_busy), .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word),
`ifdef AXIL_CMD_ERR_EN
    .o_rsp_err(o_rsp_err),
`endif
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct { logic [31:0] word; logic err; } rsp_t;
  rsp_t sb[$];

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_bresp = OKAY, cfg_rresp = OKAY;
  bit stray = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // AXI slave: each ready/valid responds after its configured number of wait cycles.
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
    m_bresp = OKAY; m_rresp = OKAY; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_awvalid) begin m_awready = (aw_c >= aw_dly); aw_c++; end else begin m_awready = 0; aw_c = 0; end
      if (m_wvalid)  begin m_wready  = (w_c  >= w_dly);  w_c++;  end else begin m_wready  = 0; w_c  = 0; end
      if (m_arvalid) begin m_arready = (ar_c >= ar_dly); ar_c++; end else begin m_arready = 0; ar_c = 0; end
      if (stray) m_bvalid = 1;
      else if (m_bready) begin m_bvalid = (b_c >= b_dly); b_c++; end else begin m_bvalid = 0; b_c = 0; end
      if (stray) m_rvalid = 1;
      else if (m_rready) begin m_rvalid = (r_c >= r_dly); r_c++; end else begin m_rvalid = 0; r_c = 0; end
      m_bresp = cfg_bresp;
      m_rresp = cfg_rresp;
      m_rdata = cfg_rdata;
    end
  end

  // Response monitor: every strobe must match the oldest expected response.
  always @(negedge clk) begin
    rsp_t e;
    if (rst && o_rsp_stb) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_stb: got strobe with word %h, expected none", o_rsp_word);
      end else begin
        e = sb.pop_front();
        check("rsp_word", o_rsp_word, e.word);
`ifdef AXIL_CMD_ERR_EN
        check("rsp_err", 32'(o_rsp_err), 32'(e.err));
`endif
        check("busy_at_stb", 32'(o_cmd_busy), 0);
      end
    end
  end

  // Called at a negedge. Returns at the negedge on which o_rsp_stb is seen (lat = -1 on timeout).
  task automatic run_cmd(input string nm, input logic wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] exp_addr, input logic [31:0] exp_word, input logic exp_err,
                         input bit hold, output int lat, output int aw_n, output int w_n,
                         output int ar_n, output int acc);
    int viol = 0;
    int k = 0;
    i_valid = 1; i_write = wr; i_addr = a; i_data = d;
    while (o_cmd_busy && k < 50) begin @(negedge clk); k++; end
    acc = cyc;
    @(posedge clk);
    sb.push_back('{exp_word, exp_err});
    aw_n = 0; w_n = 0; ar_n = 0; lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) i_valid = 0;
      if (o_rsp_stb) begin lat = cyc - acc; break; end
      if (m_awvalid) begin aw_n++; if (m_awaddr !== exp_addr) viol++; end
      if (m_wvalid)  begin w_n++;  if (m_wdata !== d || m_wstrb !== 4'hF) viol++; end
      if (m_arvalid) begin ar_n++; if (m_araddr !== exp_addr) viol++; end
      if (m_bready && (m_awvalid || m_wvalid)) viol++;
      if ((m_bready && !wr) || (m_rready && wr)) viol++;
      if (!o_cmd_busy) viol++;
    end
    check({nm, "_protocol_violations"}, viol, 0);
  endtask

  initial begin
    int lat, aw_n, w_n, ar_n, acc, acc2, k;
    rst = 0; i_valid = 0; i_write = 0; i_data = '0; i_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs", 32'({o_cmd_busy, o_rsp_stb, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 0);
    check("reset_rsp_word", o_rsp_word, 0);
    check("reset_addr", m_awaddr | m_araddr | m_wdata, 0);
    rst = 1;
    @(negedge clk);

    // Zero-wait write
    run_cmd("wr0", 1, 4'h3, 32'hA5A5_0001, 32'hFFFF_FFFC, 32'h0, 1'b0, 0, lat, aw_n, w_n, ar_n, acc);
    check("wr0_latency", lat, 3);
    check("wr0_aw_cycles", aw_n, 1);
    check("wr0_w_cycles", w_n, 1);

    // Skewed write: AW ready after 4 wait cycles
    @(negedge clk); aw_dly = 4;
    run_cmd("wr_skew", 1, 4'h1, 32'h1234_5678, 32'hFFFF_FFF4, 32'h0, 1'b0, 0, lat, aw_n, w_n, ar_n, acc);
    check("wr_skew_w_cycles", w_n, 1);
    check("wr_skew_aw_cycles", aw_n, 5);
    check("wr_skew_latency", lat, 7);
    aw_dly = 0;

    // Read with address wrap and 2 wait cycles on R
    @(negedge clk); r_dly = 2; cfg_rdata = 32'hDEAD_BEEF;
    run_cmd("rd_wrap", 0, 4'hF, 32'h0, 32'h0000_002C, 32'hDEAD_BEEF, 1'b0, 0, lat, aw_n, w_n, ar_n, acc);
    check("rd_wrap_ar_cycles", ar_n, 1);
    check("rd_wrap_latency", lat, 5);
    r_dly = 0;

    // Stray B/R valids in IDLE must be ignored
    @(negedge clk); stray = 1;
    repeat (3) @(negedge clk);
    check("stray_busy", 32'(o_cmd_busy), 0);
    check("stray_readies", 32'({m_bready, m_rready}), 0);
    stray = 0;
    repeat (2) @(negedge clk);
    check("rd_word_held", o_rsp_word, 32'hDEAD_BEEF);

    // Back-to-back: i_valid held through busy, next command issued in the strobe cycle
    cfg_rdata = 32'h0BAD_F00D;
    run_cmd("b2b_wr", 1, 4'h5, 32'hCAFE_0005, 32'h0000_0004, 32'h0, 1'b0, 1, lat, aw_n, w_n, ar_n, acc);
    check("b2b_wr_latency", lat, 3);
    check("b2b_busy_at_stb", 32'(o_cmd_busy), 0);
    run_cmd("b2b_rd", 0, 4'h0, 32'h0, 32'hFFFF_FFF0, 32'h0BAD_F00D, 1'b0, 0, lat, aw_n, w_n, ar_n, acc2);
    check("b2b_accept_cycle", acc2 - acc, 3);
    check("b2b_rd_latency", lat, 3);

    // Reset in RD_DATA
    @(negedge clk); r_dly = 10; cfg_rdata = 32'h7777_7777;
    i_valid = 1; i_write = 0; i_addr = 4'h7;
    @(posedge clk);
    @(negedge clk); i_valid = 0;
    k = 0;
    while (!m_rready && k < 20) begin @(negedge clk); k++; end
    check("rst_reached_rd_data", 32'(m_rready), 1);
    rst = 0;
    #1;
    check("rst_ctrl_outputs", 32'({o_cmd_busy, o_rsp_stb, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 0);
    check("rst_rsp_word", o_rsp_word, 0);
    check("rst_addr", m_awaddr | m_araddr | m_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    check("rst_no_late_stb_word", o_rsp_word, 0);
    r_dly = 0; cfg_rdata = 32'h5555_AAAA;
    run_cmd("rd_after_rst", 0, 4'h2, 32'h0, 32'hFFFF_FFF8, 32'h5555_AAAA, 1'b0, 0, lat, aw_n, w_n, ar_n, acc);
    check("rd_after_rst_latency", lat, 3);

    // Error reporting: SLVERR write followed by OKAY read
    @(negedge clk); cfg_bresp = SLVERR; cfg_rresp = OKAY; cfg_rdata = 32'h1357_9BDF;
    run_cmd("wr_slverr", 1, 4'h1, 32'h0000_00E1, 32'hFFFF_FFF4, 32'h0, 1'b1, 0, lat, aw_n, w_n, ar_n, acc);
    check("wr_slverr_latency", lat, 3);
    @(negedge clk); cfg_bresp = OKAY;
    run_cmd("rd_okay", 0, 4'h4, 32'h0, 32'h0000_0000, 32'h1357_9BDF, 1'b0, 0, lat, aw_n, w_n, ar_n, acc);
    check("rd_okay_latency", lat, 3);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
